// File: rtl/decode_stage.sv
// decode_stage: pipelined decode for the 32-bit R/J/I/S ISA.
// Splits instruction fields, reads a 2R/1W register file, extends the
// immediate and presents the result in a valid/ready output register.
// An accepted stop instruction parks the stage in HALT until flush.
// Optional build macro: WB_FORWARD_EN -- when defined, a same-cycle
// write-back to a source register is bypassed into the captured operand.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc_next,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_opcode,
  output logic [1:0]      out_type,
  output logic [4:0]      out_rd,
  output logic            out_rd_valid,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic            out_stop,
  output logic [XLEN-1:0] out_pc_next,
  output logic            halted
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [1:0] T_R = 2'b00;
  localparam logic [1:0] T_J = 2'b01;
  localparam logic [1:0] T_I = 2'b10;
  localparam logic [1:0] T_S = 2'b11;
  localparam logic [5:0] NREG_L = 6'(NREG);

  state_t state_reg, state_next;

  // Full 32-entry array; entries 0 and >= NREG are never written so they read 0.
  logic [XLEN-1:0] rf_reg [32];

  logic            out_valid_reg;
  logic [4:0]      out_opcode_reg;
  logic [1:0]      out_type_reg;
  logic [4:0]      out_rd_reg;
  logic            out_rd_valid_reg;
  logic [XLEN-1:0] out_rs1_data_reg;
  logic [XLEN-1:0] out_rs2_data_reg;
  logic [XLEN-1:0] out_imm_reg;
  logic            out_stop_reg;
  logic [XLEN-1:0] out_pc_next_reg;

  // Instruction fields
  logic       stop_f;
  logic [1:0] type_f;
  logic [4:0] op_f, rs1_f, rd_f, rs2_f, sa_f;

  assign stop_f = in_instr[31];
  assign type_f = in_instr[30:29];
  assign op_f   = in_instr[4:0];
  assign rs1_f  = in_instr[9:5];
  assign rd_f   = in_instr[14:10];
  assign rs2_f  = in_instr[19:15];
  assign sa_f   = in_instr[24:20];

  logic use_rs1, use_rs2, use_rd;
  logic accept;
  logic wb_hit;
  logic [4:0]      rd_idx  [2];
  logic [XLEN-1:0] rd_data [2];
  logic [XLEN-1:0] imm_next;
  logic [4:0]      rd_next;

  // Which index fields the instruction type actually uses
  always_comb begin
    use_rs1 = (type_f != T_J);
    use_rs2 = (type_f == T_R) || (type_f == T_S);
    use_rd  = (type_f != T_J);
  end

  // Unused index fields are forced to 0 so the operand reads as 0
  assign rd_idx[0] = use_rs1 ? rs1_f : 5'd0;
  assign rd_idx[1] = use_rs2 ? rs2_f : 5'd0;
  assign rd_next   = use_rd  ? rd_f  : 5'd0;

  // A write counts only for a nonzero index inside the implemented file
  assign wb_hit = wb_en && (wb_rd != 5'd0) && ({1'b0, wb_rd} < NREG_L);

  // Two read ports, optionally bypassing the same-cycle write-back
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef WB_FORWARD_EN
    assign rd_data[gi] = (wb_hit && (wb_rd == rd_idx[gi])) ? wb_data : rf_reg[rd_idx[gi]];
`else
    assign rd_data[gi] = rf_reg[rd_idx[gi]];
`endif
  end

  // Immediate extension by instruction type
  always_comb begin
    imm_next = '0;
    case (type_f)
      T_J: imm_next = {{(XLEN-24){in_instr[28]}}, in_instr[28:5]};
      T_I: begin
        if (op_f[4]) imm_next = {{(XLEN-14){1'b0}}, in_instr[28:15]};
        else         imm_next = {{(XLEN-14){in_instr[28]}}, in_instr[28:15]};
      end
      T_S: imm_next = {{(XLEN-5){1'b0}}, sa_f};
      default: imm_next = '0;
    endcase
  end

  assign in_ready = !flush && (state_reg == RUN) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Register-file write port; reset clears every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
    end else if (wb_hit) begin
      rf_reg[wb_rd] <= wb_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // FSM next state: flush always returns to RUN, accepted stop enters HALT
  always_comb begin
    state_next = state_reg;
    if (flush)                 state_next = RUN;
    else if (accept && stop_f) state_next = HALT;
  end

  // Output bundle register: flush kills, accept loads, consume clears valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      out_opcode_reg   <= '0;
      out_type_reg     <= '0;
      out_rd_reg       <= '0;
      out_rd_valid_reg <= 1'b0;
      out_rs1_data_reg <= '0;
      out_rs2_data_reg <= '0;
      out_imm_reg      <= '0;
      out_stop_reg     <= 1'b0;
      out_pc_next_reg  <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg    <= 1'b1;
      out_opcode_reg   <= op_f;
      out_type_reg     <= type_f;
      out_rd_reg       <= rd_next;
      out_rd_valid_reg <= use_rd && (rd_f != 5'd0);
      out_rs1_data_reg <= rd_data[0];
      out_rs2_data_reg <= rd_data[1];
      out_imm_reg      <= imm_next;
      out_stop_reg     <= stop_f;
      out_pc_next_reg  <= in_pc_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_opcode   = out_opcode_reg;
  assign out_type     = out_type_reg;
  assign out_rd       = out_rd_reg;
  assign out_rd_valid = out_rd_valid_reg;
  assign out_rs1_data = out_rs1_data_reg;
  assign out_rs2_data = out_rs2_data_reg;
  assign out_imm      = out_imm_reg;
  assign out_stop     = out_stop_reg;
  assign out_pc_next  = out_pc_next_reg;
  assign halted       = (state_reg == HALT);

endmodule
